// File: rtl/shift_reg_univ.sv
// Universal shift register: PIPO, PISO, SIPO and SISO transfers with a
// valid/ready parallel-load handshake and a valid-qualified serial input.
module shift_reg_univ #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pdin,
    input  logic             sdin,
    input  logic             sdin_valid,
    output logic [WIDTH-1:0] pdout,
    output logic             pdout_valid,
    output logic             sdout,
    output logic             sdout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [1:0] M_PIPO = 2'b00;
    localparam logic [1:0] M_PISO = 2'b01;
    localparam logic [1:0] M_SIPO = 2'b10;

    logic [0:0]       state, state_d;
    logic [1:0]       mode_q, mode_q_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] pdout_d;
    logic             pdout_valid_d;
    logic             sdout_d;
    logic             sdout_valid_d;
    logic             busy_d;
    logic             done_d;

    logic             mode_chg;
    logic [WIDTH-1:0] sreg_base;
    logic [CW-1:0]    cnt_base;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] piso_next;
    logic             out_bit;

    // A new mode seen in IDLE starts from an empty register and zero count.
    assign mode_chg   = (state == S_IDLE) && (mode != mode_q);
    assign sreg_base  = mode_chg ? '0 : sreg;
    assign cnt_base   = mode_chg ? '0 : cnt;
    assign shift_in   = LSB_FIRST ? {sdin, sreg_base[WIDTH-1:1]} : {sreg_base[WIDTH-2:0], sdin};
    assign piso_next  = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
    assign out_bit    = LSB_FIRST ? sreg_base[0] : sreg_base[WIDTH-1];
    assign load_ready = (state == S_IDLE) & ~mode[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= M_PIPO;
            sreg        <= '0;
            cnt         <= '0;
            pdout       <= '0;
            pdout_valid <= 1'b0;
            sdout       <= 1'b0;
            sdout_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            mode_q      <= mode_q_d;
            sreg        <= sreg_d;
            cnt         <= cnt_d;
            pdout       <= pdout_d;
            pdout_valid <= pdout_valid_d;
            sdout       <= sdout_d;
            sdout_valid <= sdout_valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d       = state;
        mode_q_d      = mode_q;
        sreg_d        = sreg;
        cnt_d         = cnt;
        pdout_d       = pdout;
        pdout_valid_d = 1'b0;
        sdout_d       = sdout;
        sdout_valid_d = 1'b0;
        done_d        = 1'b0;

        case (state)
            S_IDLE: begin
                mode_q_d = mode;
                sreg_d   = sreg_base;
                cnt_d    = cnt_base;
                case (mode)
                    M_PIPO: begin
                        if (load_valid) begin
                            pdout_d       = pdin;
                            pdout_valid_d = 1'b1;
                        end
                    end
                    M_PISO: begin
                        if (load_valid) begin
                            sreg_d  = pdin;
                            cnt_d   = '0;
                            state_d = S_SHIFT;
                        end
                    end
                    M_SIPO: begin
                        if (sdin_valid) begin
                            sreg_d = shift_in;
                            if (cnt_base == CW'(WIDTH - 1)) begin
                                pdout_d       = shift_in;
                                pdout_valid_d = 1'b1;
                                cnt_d         = '0;
                            end else begin
                                cnt_d = cnt_base + CW'(1);
                            end
                        end
                    end
                    default: begin
                        // SISO: once WIDTH bits are held, each new bit pushes the oldest out.
                        if (sdin_valid) begin
                            sreg_d = shift_in;
                            if (cnt_base == CW'(WIDTH)) begin
                                sdout_d       = out_bit;
                                sdout_valid_d = 1'b1;
                            end else begin
                                cnt_d = cnt_base + CW'(1);
                            end
                        end
                    end
                endcase
            end
            S_SHIFT: begin
                sdout_d       = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
                sdout_valid_d = 1'b1;
                sreg_d        = piso_next;
                if (cnt == CW'(WIDTH - 1)) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SHIFT);
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed vector table and corner sequences, then
// random traffic against a queue-based reference model (WIDTH=4, MSB first).
module tb_shift_reg_univ;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] mode4, mode8;
    logic       lv4, lv8, rdy4, rdy8;
    logic [3:0] pdin4, pd4;
    logic [7:0] pdin8, pd8;
    logic       sdin4, sv4, sdin8, sv8;
    logic       pv4, so4, sov4, busy4, done4;
    logic       pv8, so8, sov8, busy8, done8;

    shift_reg_univ #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .load_valid(lv4), .load_ready(rdy4),
        .pdin(pdin4), .sdin(sdin4), .sdin_valid(sv4), .pdout(pd4), .pdout_valid(pv4),
        .sdout(so4), .sdout_valid(sov4), .busy(busy4), .done(done4)
    );

    shift_reg_univ #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .load_valid(lv8), .load_ready(rdy8),
        .pdin(pdin8), .sdin(sdin8), .sdin_valid(sv8), .pdout(pd8), .pdout_valid(pv8),
        .sdout(so8), .sdout_valid(sov8), .busy(busy8), .done(done8)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {pdout, pdout_valid, sdout, sdout_valid, busy, done}
    function automatic logic [31:0] outs4();
        return 32'({pd4, pv4, so4, sov4, busy4, done4});
    endfunction

    function automatic logic [31:0] pack4(input logic [3:0] pd, input logic pv, input logic so,
                                          input logic sov, input logic bsy, input logic dn);
        return 32'({pd, pv, so, sov, bsy, dn});
    endfunction

    typedef struct {
        logic [1:0] mode;
        logic       lv;
        logic [3:0] pdin;
        logic       sv;
        logic       sd;
        logic       rdy;
        logic [3:0] pd;
        logic       pv;
        logic       so;
        logic       sov;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] m, input logic lv, input logic [3:0] pdin, input logic sv,
                       input logic sd, input logic rdy, input logic [3:0] pd, input logic pv,
                       input logic so, input logic sov, input logic bsy, input logic dn);
        vec_t v;
        v.mode = m; v.lv = lv; v.pdin = pdin; v.sv = sv; v.sd = sd; v.rdy = rdy;
        v.pd = pd; v.pv = pv; v.so = so; v.sov = sov; v.bsy = bsy; v.dn = dn;
        tbl.push_back(v);
    endtask

    task automatic drive4(input logic [1:0] m, input logic lv, input logic [3:0] pd,
                          input logic sv, input logic sd);
        @(negedge clk);
        mode4 = m; lv4 = lv; pdin4 = pd; sv4 = sv; sdin4 = sd;
    endtask

    // Reference model: pending serial bits kept as a queue, word formed arithmetically.
    bit         m_shift;
    logic [1:0] m_mode;
    bit         m_q[$];
    logic [3:0] m_pd;
    logic       m_sd;
    logic       e_pv, e_sov, e_dn;

    task automatic model_reset();
        m_shift = 1'b0; m_mode = 2'b00; m_q.delete(); m_pd = '0; m_sd = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] m, input logic lv, input logic [3:0] pdin,
                              input logic sv, input logic sd);
        int word;
        e_pv = 1'b0; e_sov = 1'b0; e_dn = 1'b0;
        if (!m_shift) begin
            if (m != m_mode) begin
                m_q.delete();
                m_mode = m;
            end
            case (m)
                2'd0: if (lv) begin m_pd = pdin; e_pv = 1'b1; end
                2'd1: if (lv) begin
                    m_q.delete();
                    for (int i = 3; i >= 0; i--) m_q.push_back(pdin[i]);
                    m_shift = 1'b1;
                end
                2'd2: if (sv) begin
                    m_q.push_back(sd);
                    if (m_q.size() == 4) begin
                        word = 0;
                        foreach (m_q[i]) word = word * 2 + int'(m_q[i]);
                        m_pd = 4'(word);
                        e_pv = 1'b1;
                        m_q.delete();
                    end
                end
                default: if (sv) begin
                    m_q.push_back(sd);
                    if (m_q.size() > 4) begin
                        m_sd  = m_q.pop_front();
                        e_sov = 1'b1;
                    end
                end
            endcase
        end else begin
            m_sd  = m_q.pop_front();
            e_sov = 1'b1;
            if (m_q.size() == 0) begin
                e_dn    = 1'b1;
                m_shift = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] w8;
        logic [3:0] w4;

        rst_n = 1'b0;
        mode4 = 2'b00; lv4 = 1'b0; pdin4 = '0; sdin4 = 1'b0; sv4 = 1'b0;
        mode8 = 2'b00; lv8 = 1'b0; pdin8 = '0; sdin8 = 1'b0; sv8 = 1'b0;
        #12;
        chk("reset_outs4", outs4(), 32'd0);
        chk("reset_outs8", 32'({pd8, pv8, so8, sov8, busy8, done8}), 32'd0);
        chk("reset_ready4", 32'(rdy4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // PIPO stream, PISO 1011, SIPO with gaps, SISO delay line
        add(2'd0, 1, 4'hA, 0, 0, 1, 4'hA, 1, 0, 0, 0, 0);
        add(2'd0, 1, 4'hB, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0);
        add(2'd0, 1, 4'hE, 0, 0, 1, 4'hE, 1, 0, 0, 0, 0);
        add(2'd0, 1, 4'hF, 0, 0, 1, 4'hF, 1, 0, 0, 0, 0);
        add(2'd0, 0, 4'h0, 0, 0, 1, 4'hF, 0, 0, 0, 0, 0);
        add(2'd1, 1, 4'hB, 0, 0, 1, 4'hF, 0, 0, 0, 1, 0);
        add(2'd1, 0, 4'h0, 0, 0, 0, 4'hF, 0, 1, 1, 1, 0);
        add(2'd1, 0, 4'h0, 0, 0, 0, 4'hF, 0, 0, 1, 1, 0);
        add(2'd1, 0, 4'h0, 0, 0, 0, 4'hF, 0, 1, 1, 1, 0);
        add(2'd1, 0, 4'h0, 0, 0, 0, 4'hF, 0, 1, 1, 0, 1);
        add(2'd1, 0, 4'h0, 0, 0, 1, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 1, 1, 0, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 0, 0, 0, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 1, 1, 0, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 1, 1, 0, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 0, 1, 0, 4'hF, 0, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 1, 0, 0, 4'hE, 1, 1, 0, 0, 0);
        add(2'd2, 0, 4'h0, 0, 0, 0, 4'hE, 0, 1, 0, 0, 0);
        add(2'd3, 0, 4'h0, 1, 1, 0, 4'hE, 0, 1, 0, 0, 0);
        add(2'd3, 0, 4'h0, 1, 0, 0, 4'hE, 0, 1, 0, 0, 0);
        add(2'd3, 0, 4'h0, 1, 0, 0, 4'hE, 0, 1, 0, 0, 0);
        add(2'd3, 0, 4'h0, 1, 1, 0, 4'hE, 0, 1, 0, 0, 0);
        add(2'd3, 0, 4'h0, 1, 1, 0, 4'hE, 0, 1, 1, 0, 0);
        add(2'd3, 0, 4'h0, 1, 1, 0, 4'hE, 0, 0, 1, 0, 0);
        add(2'd3, 0, 4'h0, 0, 0, 0, 4'hE, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive4(tbl[i].mode, tbl[i].lv, tbl[i].pdin, tbl[i].sv, tbl[i].sd);
            #1 chk($sformatf("tbl%0d_ready", i), 32'(rdy4), 32'(tbl[i].rdy));
            @(posedge clk);
            #1 chk($sformatf("tbl%0d_outs", i), outs4(),
                   pack4(tbl[i].pd, tbl[i].pv, tbl[i].so, tbl[i].sov, tbl[i].bsy, tbl[i].dn));
        end

        // PISO LSB-first, 8 bits, with load_valid held through SHIFT
        w8 = 8'hA5;
        @(negedge clk);
        mode8 = 2'd1; lv8 = 1'b1; pdin8 = w8;
        #1 chk("p8_ready_idle", 32'(rdy8), 32'd1);
        @(posedge clk);
        #1 chk("p8_busy_sov", 32'({busy8, sov8}), 32'b10);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                pdin8 = (k == 0) ? 8'hFF : 8'h00;
                #1 chk("p8_ready_shift", 32'(rdy8), 32'd0);
                @(posedge clk);
                #1 chk($sformatf("p8_w%0d_bit%0d", k, i), 32'({so8, sov8, done8, busy8}),
                       32'({w8[i], 1'b1, i == 7, i != 7}));
            end
            if (k == 0) begin
                w8 = 8'h3C;
                @(negedge clk);
                pdin8 = w8;
                #1 chk("p8_ready_again", 32'(rdy8), 32'd1);
                @(posedge clk);
                #1 chk("p8_reload", 32'({busy8, sov8}), 32'b10);
                lv8 = 1'b0;
            end
        end

        // Abort a PISO word after two bits, then restart
        drive4(2'd1, 1, 4'hB, 0, 0);
        @(posedge clk);
        drive4(2'd1, 0, 4'h0, 0, 0);
        @(posedge clk);
        #1 chk("abort_bit0", 32'({so4, sov4}), 32'b11);
        @(posedge clk);
        #1 chk("abort_bit1", 32'({so4, sov4}), 32'b01);
        #2 rst_n = 1'b0;
        #1 chk("abort_outs_zero", outs4(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("abort_quiet", 32'({busy4, sov4, done4}), 32'd0);
        end
        w4 = 4'h6;
        drive4(2'd1, 1, w4, 0, 0);
        @(posedge clk);
        drive4(2'd1, 0, 4'h0, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk);
            #1 chk($sformatf("restart_bit%0d", i), 32'({so4, sov4, done4}),
                   32'({w4[i], 1'b1, i == 0}));
        end

        // Random traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        mode4 = 2'd0; lv4 = 1'b0; sv4 = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode4 = 2'($urandom_range(0, 3));
            lv4   = 1'($urandom_range(0, 1));
            pdin4 = 4'($urandom);
            sv4   = ($urandom_range(0, 3) != 0);
            sdin4 = 1'($urandom_range(0, 1));
            #1 chk("rand_ready", 32'(rdy4), 32'(!m_shift && !mode4[1]));
            model_step(mode4, lv4, pdin4, sv4, sdin4);
            @(posedge clk);
            #1 chk("rand_outs", outs4(), pack4(m_pd, e_pv, m_sd, e_sov, m_shift, e_dn));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
